debounced_encoder4_2: RTL and testbench

//  Inverse of the 2->4 decoder: encodes 4 asynchronous request lines (buttons/keys) into a 2-bit code.

---
 rtl/enc_pkg.sv | 12 +
 rtl/priority_encoder4_2.sv | 23 ++
 rtl/debounced_encoder4_2.sv | 114 +++++++++++
 tb/tb_debounced_encoder4_2.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared encoder/decoder constants and the debounce FSM state encoding.
package enc_pkg;
  localparam int unsigned ENC_W = 2;
  localparam int unsigned REQ_W = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_t;
endpackage

// File: rtl/priority_encoder4_2.sv
// Combinational 4->2 priority encoder; highest set bit wins, flags any/multiple bits set.
module priority_encoder4_2
  import enc_pkg::*;
(
  input  logic [REQ_W-1:0] i,
  output logic [ENC_W-1:0] o,
  output logic             any,
  output logic             multi
);

  always_comb begin
    o = ENC_W'(0);
    if (i[3])      o = ENC_W'(3);
    else if (i[2]) o = ENC_W'(2);
    else if (i[1]) o = ENC_W'(1);
  end

  assign any = |i;

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign multi = |(i & (i - REQ_W'(1)));

endmodule

// File: rtl/debounced_encoder4_2.sv
// Synchronises, debounces and priority-encodes four request lines into a 2-bit command
// index, issuing one valid pulse per accepted press.
module debounced_encoder4_2
  import enc_pkg::*;
#(
  parameter int unsigned DEB_CNT = 100000,
  parameter int unsigned CNT_W   = 17
) (
  input  logic             clk,
  input  logic             reset_p,
  input  logic [REQ_W-1:0] i,
  output logic [ENC_W-1:0] o,
  output logic             valid,
  output logic             held,
  output logic             multi
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEB_CNT - 1);

  logic [REQ_W-1:0] sync1, s;
  logic [REQ_W-1:0] snap, snap_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  state_t           state, state_n;
  logic [ENC_W-1:0] o_n;
  logic             valid_n, held_n, multi_n;
  logic [ENC_W-1:0] enc_o;
  logic             enc_any, enc_multi;

  priority_encoder4_2 u_enc (
    .i     (snap),
    .o     (enc_o),
    .any   (enc_any),
    .multi (enc_multi)
  );

  // State, synchroniser and output registers.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      sync1 <= '0;
      s     <= '0;
      state <= IDLE;
      cnt   <= '0;
      snap  <= '0;
      o     <= '0;
      valid <= 1'b0;
      held  <= 1'b0;
      multi <= 1'b0;
    end else begin
      sync1 <= i;
      s     <= sync1;
      state <= state_n;
      cnt   <= cnt_n;
      snap  <= snap_n;
      o     <= o_n;
      valid <= valid_n;
      held  <= held_n;
      multi <= multi_n;
    end
  end

  // Next-state and next-output logic; o/multi only move on the accepting edge.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    snap_n  = snap;
    o_n     = o;
    multi_n = multi;
    held_n  = held;
    valid_n = 1'b0;
    case (state)
      IDLE: begin
        if (s != '0) begin
          state_n = DEBOUNCE;
          snap_n  = s;
          cnt_n   = '0;
        end
      end
      DEBOUNCE: begin
        if (s == '0) begin
          state_n = IDLE;
        end else if (s != snap) begin
          snap_n = s;
          cnt_n  = '0;
        end else if (cnt == LAST && enc_any) begin
          state_n = PRESSED;
          o_n     = enc_o;
          multi_n = enc_multi;
          valid_n = 1'b1;
          held_n  = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (s == '0) begin
          state_n = RELEASE;
          cnt_n   = '0;
        end
      end
      RELEASE: begin
        if (s != '0) begin
          state_n = PRESSED;
        end else if (cnt == LAST) begin
          state_n = IDLE;
          held_n  = 1'b0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_debounced_encoder4_2.sv
// Scoreboard bench for debounced_encoder4_2 with DEB_CNT=4: expected press events are queued
// with their due cycle, and a monitor checks every valid pulse against the queue.
module tb_debounced_encoder4_2;
  import enc_pkg::*;

  typedef struct {
    logic [1:0] o;
    logic       multi;
    int         cyc;
  } exp_t;

  logic       clk;
  logic       reset_p;
  logic [3:0] i;
  logic [1:0] o;
  logic       valid, held, multi;

  int   cyc;
  int   n_cmp;
  int   n_bad;
  exp_t q[$];

  debounced_encoder4_2 #(.DEB_CNT(4), .CNT_W(3)) dut (
    .clk     (clk),
    .reset_p (reset_p),
    .i       (i),
    .o       (o),
    .valid   (valid),
    .held    (held),
    .multi   (multi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every valid pulse must match the oldest queued expectation, on its due cycle.
  always @(negedge clk) begin
    if (valid) begin
      exp_t e;
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_valid: cyc=%0d o=%0d multi=%0b, required no pulse", cyc, o, multi);
      end else begin
        e = q.pop_front();
        if (o !== e.o || multi !== e.multi || cyc != e.cyc) begin
          n_bad++;
          $display("FAIL press_event: got o=%0d multi=%0b cyc=%0d, required o=%0d multi=%0b cyc=%0d",
                   o, multi, cyc, e.o, e.multi, e.cyc);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: cyc=%0d got %0d, required %0d", name, cyc, act, req);
    end
  endtask

  task automatic expect_press(input logic [1:0] eo, input logic em, input int due);
    exp_t e;
    e.o = eo;
    e.multi = em;
    e.cyc = due;
    q.push_back(e);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;

    // 1: reset with a line already asserted
    reset_p = 1'b1;
    i = 4'b1000;
    tick(3);
    check("reset_o", 4'(o), 4'd0);
    check("reset_valid", 4'(valid), 4'd0);
    check("reset_held", 4'(held), 4'd0);
    check("reset_multi", 4'(multi), 4'd0);
    reset_p = 1'b0;
    expect_press(2'd3, 1'b0, cyc + 7);
    tick(12);
    check("t1_held", 4'(held), 4'd1);
    i = 4'b0000;
    tick(6);
    check("t1_held_before_release", 4'(held), 4'd1);
    tick(1);
    check("t1_held_released", 4'(held), 4'd0);
    check("t1_o_kept_idle", 4'(o), 4'd3);
    tick(3);

    // 2: clean press
    i = 4'b0100;
    expect_press(2'd2, 1'b0, cyc + 7);
    tick(20);
    check("t2_o", 4'(o), 4'd2);
    i = 4'b0000;
    tick(6);
    check("t2_held_before_release", 4'(held), 4'd1);
    tick(1);
    check("t2_held_released", 4'(held), 4'd0);
    tick(5);

    // 3: bouncing press settles on 0010
    for (int k = 0; k < 6; k++) begin
      i = (k % 2 == 0) ? 4'b0010 : 4'b0000;
      tick(1);
    end
    i = 4'b0010;
    expect_press(2'd1, 1'b0, cyc + 7);
    tick(10);
    check("t3_o", 4'(o), 4'd1);
    check("t3_held", 4'(held), 4'd1);
    i = 4'b0000;
    tick(10);
    check("t3_held_released", 4'(held), 4'd0);

    // 4: multi-line press, then pattern change while pressed
    i = 4'b0101;
    expect_press(2'd2, 1'b1, cyc + 7);
    tick(10);
    i = 4'b0001;
    tick(5);
    check("t4_o_frozen", 4'(o), 4'd2);
    check("t4_multi_frozen", 4'(multi), 4'd1);
    i = 4'b0000;
    tick(10);
    check("t4_held_released", 4'(held), 4'd0);

    // 5: release bounce keeps held
    i = 4'b0100;
    expect_press(2'd2, 1'b0, cyc + 7);
    tick(10);
    i = 4'b0000;
    tick(2);
    i = 4'b0100;
    for (int k = 0; k < 12; k++) begin
      tick(1);
      check("t5_held_through_bounce", 4'(held), 4'd1);
    end
    check("t5_multi", 4'(multi), 4'd0);
    i = 4'b0000;
    tick(6);
    check("t5_held_before_release", 4'(held), 4'd1);
    tick(1);
    check("t5_held_released", 4'(held), 4'd0);
    tick(3);

    // 6: reset in the middle of debouncing (counter at 2)
    i = 4'b0001;
    tick(5);
    reset_p = 1'b1;
    tick(1);
    check("t6_reset_valid", 4'(valid), 4'd0);
    check("t6_reset_held", 4'(held), 4'd0);
    check("t6_reset_o", 4'(o), 4'd0);
    reset_p = 1'b0;
    expect_press(2'd0, 1'b0, cyc + 7);
    tick(12);
    check("t6_held", 4'(held), 4'd1);
    i = 4'b0000;
    tick(10);
    check("t6_held_released", 4'(held), 4'd0);

    check("pending_expectations", 4'(q.size()), 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
